// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t  : fetch controller states
//   NOP_INST       : instruction presented to IF/ID while nothing valid is held
//   PC_ALIGN_MASK  : clears the two byte-offset bits of a word address
//   align_pc()     : word-aligns an arbitrary target address
// ---------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_KILL  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_skid_reg.sv
// ---------------------------------------------------------------------------
// if_skid_reg
// One-entry holding register for a fetched instruction and its PC. It catches
// a memory response that arrives while the downstream buffer is stalled.
// Ports:
//   clk, rst          : clock, synchronous active-low reset (empties entry)
//   load              : capture load_inst/load_pc, entry becomes full
//   unload            : entry has been consumed, becomes empty
//   flush             : discard entry (wins over load and unload)
//   load_inst/load_pc : data to capture
//   full              : entry holds a pending instruction
//   inst/pc           : held instruction and its PC
// ---------------------------------------------------------------------------
module if_skid_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        full,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    // Data is only meaningful while full is set, so flush and unload only
    // clear the flag and leave the payload untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 1'b0;
            inst <= 32'h0;
            pc   <= 32'h0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            inst <= load_inst;
            pc   <= load_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage feeding the IF/ID pipeline buffer. Owns the PC,
// runs a request/ready handshake with a variable-latency instruction memory
// and uses a one-entry skid register so a response landing during a
// downstream stall is neither lost nor delivered twice.
//
// Parameters:
//   RESET_PC : PC loaded on reset
//   PC_STEP  : sequential PC increment in bytes
// Ports:
//   clk, rst             : clock, synchronous active-low reset
//   stall                : downstream buffer holding, outputs frozen
//   redirect/redirect_pc : taken branch/jump pulse and its target
//   imem_req/imem_addr   : fetch request, held with stable address until ready
//   imem_ready/imem_rdata: response strobe and instruction word
//   inst_o/pc_o          : instruction and its PC towards IF/ID
//   pc_plus4_o           : pc_o + PC_STEP (link value)
//   valid_o              : inst_o holds a real instruction
//   clear_o              : one-cycle IF/ID flush on redirect
//   fetch_cnt_o          : delivered-instruction counter (IF_PERF_CNT_EN)
//   stall_cnt_o          : stalled-cycle counter (IF_PERF_CNT_EN)
// Build option: define IF_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        clear_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  kill_addr;

    logic         skid_load;
    logic         skid_unload;
    logic         skid_flush;
    logic         skid_full;
    logic [31:0]  skid_inst;
    logic [31:0]  skid_pc;

    logic         deliver_now;

    // While a request is being killed the memory still sees the old address
    // until it answers; pc already holds the redirect target by then.
    assign imem_addr = (state == S_KILL) ? kill_addr : pc;

    assign clear_o = redirect & rst;

    // A response that arrives while the buffer is stalled is parked in the
    // skid; it drains the first cycle stall is released.
    assign skid_load   = rst && !redirect && (state == S_FETCH) && imem_ready && stall;
    assign skid_unload = rst && !redirect && (state == S_HOLD) && skid_full && !stall;
    assign skid_flush  = rst && redirect;

    // Asserted whenever a fresh instruction is written to the outputs.
    assign deliver_now = (rst && !redirect && (state == S_FETCH) && imem_ready && !stall)
                         || skid_unload;

    if_skid_reg u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (skid_flush),
        .load_inst (imem_rdata),
        .load_pc   (pc),
        .full      (skid_full),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );

    // Fetch controller. imem_req is registered alongside the state so it
    // always reflects the state being entered. Redirect outranks everything
    // except reset; a redirect arriving while a request is still unanswered
    // parks the controller in S_KILL to swallow that stale response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_RESET;
            imem_req   <= 1'b0;
            pc         <= RESET_PC;
            kill_addr  <= RESET_PC;
            inst_o     <= NOP_INST;
            pc_o       <= RESET_PC;
            pc_plus4_o <= RESET_PC + PC_STEP;
            valid_o    <= 1'b0;
        end else if (redirect) begin
            pc      <= align_pc(redirect_pc);
            valid_o <= 1'b0;
            if ((state == S_FETCH) && !imem_ready) begin
                state     <= S_KILL;
                kill_addr <= pc;
                imem_req  <= 1'b1;
            end else if ((state == S_KILL) && !imem_ready) begin
                state    <= S_KILL;
                imem_req <= 1'b1;
            end else begin
                state    <= S_FETCH;
                imem_req <= 1'b1;
            end
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        pc <= pc + PC_STEP;
                        if (!stall) begin
                            inst_o     <= imem_rdata;
                            pc_o       <= pc;
                            pc_plus4_o <= pc + PC_STEP;
                            valid_o    <= 1'b1;
                        end else begin
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (!stall) begin
                        valid_o <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (skid_unload) begin
                        inst_o     <= skid_inst;
                        pc_o       <= skid_pc;
                        pc_plus4_o <= skid_pc + PC_STEP;
                        valid_o    <= 1'b1;
                        state      <= S_FETCH;
                        imem_req   <= 1'b1;
                    end
                end
                S_KILL: begin
                    if (imem_ready) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state    <= S_RESET;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_o <= 32'h0;
            stall_cnt_o <= 32'h0;
        end else begin
            if (deliver_now) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (stall) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`else
    logic unused_deliver;
    assign unused_deliver = deliver_now;
`endif

endmodule
